adam_mem_copy: RTL and testbench
================================

# adam_mem_copy

Memory-port initiator that copies or fills a block of words through the single-port `req/addr/we/be/wdata/rdata` memory interface used by the ADAM on-chip RAMs. It drives the master side of that port. It also uses the port's fixed one-cycle read latency, where `rdata` is registered on the clock edge after `addr` is presented. Software or a control FSM programs source, destination, length and mode, pulses `start`, and waits for `done`. It sits beside a RAM instance and serves boot-time clearing, image relocation and buffer initialisation.

## Interface
- `ADAM_CFG_PARAMS`: standard ADAM config set (`ADDR_WIDTH`, `DATA_WIDTH`, `STRB_WIDTH`, `ADDR_T`, `DATA_T`, `STRB_T`).
- `LEN_WIDTH`, default 16: width of the word-count input; maximum transfer is 2^LEN_WIDTH-1 words.
- `seq`  in  ADAM_SEQ.Slave  clock `seq.clk` and reset `seq.rst`. One clock. Reset is asynchronous and active-low.
- `start`  in  1  one-cycle request to begin; sampled only in IDLE.
- `fill`  in  1  0 = copy src→dst, 1 = write `pattern` to dst; sampled at start.
- `src_addr`  in  ADDR_T  byte address of first source word; sampled at start.
- `dst_addr`  in  ADDR_T  byte address of first destination word; sampled at start.
- `len`  in  LEN_WIDTH  number of words; sampled at start.
- `pattern`  in  DATA_T  fill value; sampled at start.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse at completion.
- `error`  out  1  one-cycle pulse coincident with `done` when the request was rejected.
- `req`  out  1  memory access strobe.
- `addr`  out  ADDR_T  memory byte address, word-aligned.
- `we`  out  1  memory write enable.
- `be`  out  STRB_T  byte enables; all ones on writes, zero otherwise.
- `wdata`  out  DATA_T  write data.
- `rdata`  in  DATA_T  read data, valid the cycle after a read is presented.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- **IDLE**: all memory outputs are 0. On `start`, the block latches `fill`, `src`, `dst`, `len` and `pattern`.
  - If either address has nonzero bits [$clog2(STRB_WIDTH)-1:0] and the corresponding mode uses it, the request is rejected: go to FINISH with the error flag set. In fill mode, `src_addr` alignment is ignored.
  - If `len`=0: go to FINISH, no error, and no memory access.
  - Otherwise go to READ in copy mode or WRITE in fill mode.
- **READ**: `req`=1, `we`=0, `be`=0, `addr`=current src. Next state is WRITE.
- **WRITE**: `req`=1, `we`=1, `be`=all ones, `addr`=current dst.
  - `wdata` is `rdata` in copy mode and the latched pattern in fill mode.
  - Then src and dst advance by STRB_WIDTH and the remaining count decrements.
  - If remaining was 1, go to FINISH. Otherwise go to READ in copy mode or stay in WRITE in fill mode.
- **FINISH**: `done`=1 and `error`=error flag for one cycle, then IDLE. `busy`=0 in FINISH and IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: wrap past the top goes to 0 silently.
- Words are processed in ascending order. Overlapping regions with dst > src propagate already-copied data; this is defined behaviour, not an error.
- `start` while not in IDLE is ignored. Input changes after acceptance have no effect.
- Reset at any time: return to IDLE and drive all outputs to 0. An aborted transfer produces no `done`.

## Timing
- Reset value of every output is 0.
- Copy takes 2 cycles per word; fill takes 1 cycle per word.
- Start accepted at edge k:
  - copy: first READ in cycle k+1; `done` in cycle k+1+2·len.
  - fill: first WRITE in cycle k+1; `done` in cycle k+1+len.
  - `len`=0 or error: `done` in cycle k+1.
- `start` may be reasserted in the cycle after `done` and is accepted then.
- `wdata` in copy mode is combinational from `rdata`. No read data is buffered beyond one cycle.

## Test plan
- **Copy**: src=0x000, dst=0x100, len=4, source words 0x11111111..0x44444444 (32-bit data).
  - Required: dst words match the source.
  - Required: `done` in cycle 9 after start, `busy` high for cycles 1–8, `error`=0.
- **Fill**: dst=0x040, len=3, pattern=0xDEADBEEF.
  - Required: writes to 0x40, 0x44 and 0x48 in consecutive cycles, `done` 4 cycles after start, and 0x4C unchanged.
- **Length zero and misalignment**:
  - `len`=0 → `done` next cycle, `error`=0, `req` never asserted.
  - copy with src=0x002 → `done`+`error` next cycle, no access.
  - fill with src=0x002, dst=0x000 → accepted, no error.
- **Overlap and busy start**: copy src=0x0, dst=0x4, len=3 over words A,B,C,D → memory becomes A,A,A,A. A second `start` pulsed mid-transfer is ignored.
- **Wrap**: fill dst=2^ADDR_WIDTH−4, len=2 → writes to the top word, then to address 0.
- **Reset mid-copy**: reset asserted asynchronously during a WRITE cycle.
  - Required: outputs go to 0 immediately without waiting for a clock edge, and there is no `done`.
  - Required: a new start after reset release completes normally.

Source files
------------

// File: rtl/adam_mem_copy.sv
// rtl/adam_mem_copy.sv - block copy/fill initiator driving the single-port ADAM RAM interface
// Copy alternates READ/WRITE per word, fill streams WRITEs; outputs are registered except copy-mode wdata.
module adam_mem_copy #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  fill,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] pattern,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  we,
  output logic [STRB_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_e;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  state_e                state_q, state_d;
  logic                  fill_q, fill_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [STRB_WIDTH-1:0] be_q, be_d;
  logic                  src_bad, dst_bad;

  assign src_bad = |(src_addr & ALIGN_MASK);
  assign dst_bad = |(dst_addr & ALIGN_MASK);

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    err_d     = err_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          fill_d    = fill;
          src_d     = src_addr;
          dst_d     = dst_addr;
          cnt_d     = len;
          pattern_d = pattern;
          // Source alignment only matters when the source is actually read.
          err_d     = dst_bad || (!fill && src_bad);
          if (err_d || len == '0) state_d = FINISH;
          else                    state_d = fill ? WRITE : READ;
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        src_d = src_q + STEP;
        dst_d = dst_q + STEP;
        cnt_d = cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) state_d = FINISH;
        else                        state_d = fill_q ? WRITE : READ;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are valid from the first cycle of each state.
    busy_d  = (state_d == READ) || (state_d == WRITE);
    req_d   = busy_d;
    we_d    = (state_d == WRITE);
    be_d    = we_d ? '1 : '0;
    addr_d  = (state_d == READ) ? src_d : (state_d == WRITE) ? dst_d : '0;
    done_d  = (state_d == FINISH);
    error_d = done_d && err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fill_q    <= 1'b0;
      err_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      err_q     <= err_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign req   = req_q;
  assign we    = we_q;
  assign addr  = addr_q;
  assign be    = be_q;
  // Copy data passes straight through from the RAM's registered read port.
  assign wdata = we_q ? (fill_q ? pattern_q : rdata) : '0;

endmodule

// File: tb/tb_adam_mem_copy.sv
// tb/tb_adam_mem_copy.sv - directed and random copy/fill checks against an array reference model
// A word-array RAM with one-cycle read latency sits on the memory port; a second array holds expected contents.
module tb_adam_mem_copy;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LW = 16;
  localparam int NW = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          fill = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, error, req, we;
  logic [AW-1:0] addr;
  logic [SW-1:0] be;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;

  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];
  logic          bd_we = 1'b0;
  logic [AW-3:0] bd_idx = '0;
  logic [DW-1:0] bd_data = '0;

  logic [AW-1:0] wr_addr [$];
  int            wr_cyc  [$];
  int            n_cmp = 0;
  int            n_fail = 0;

  adam_mem_copy #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill(fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .error(error), .req(req), .addr(addr),
    .we(we), .be(be), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (req && we) begin
      for (int b = 0; b < SW; b++)
        if (be[b]) mem[addr[AW-1:2]][8*b +: 8] <= wdata[8*b +: 8];
    end else if (req) rdata <= mem[addr[AW-1:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [DW-1:0] v);
    bd_idx = AW'(idx) >> 0;
    bd_idx = idx[AW-3:0];
    bd_data = v;
    bd_we = 1'b1;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic run(input logic f, input logic [AW-1:0] s, input logic [AW-1:0] d,
                     input logic [LW-1:0] l, input logic [DW-1:0] p, input int glitch,
                     input string tag);
    int   n, exp_done, exp_acc, nacc, bad_busy, mm;
    logic rejected, err_seen;
    logic [AW-1:0] sa, da;
    rejected = (|d[1:0]) || (!f && |s[1:0]);
    exp_done = (rejected || l == 0) ? 1 : (f ? int'(l) + 1 : 2 * int'(l) + 1);
    exp_acc  = (rejected || l == 0) ? 0 : (f ? int'(l) : 2 * int'(l));
    if (!rejected)
      for (int i = 0; i < int'(l); i++) begin
        sa = s + AW'(4 * i);
        da = d + AW'(4 * i);
        ref_mem[da[AW-1:2]] = f ? p : ref_mem[sa[AW-1:2]];
      end
    wr_addr.delete();
    wr_cyc.delete();
    @(negedge clk);
    fill = f; src_addr = s; dst_addr = d; len = l; pattern = p; start = 1'b1;
    n = 0; nacc = 0; bad_busy = 0; err_seen = 1'b0;
    while (n < exp_done + 8) begin
      @(negedge clk);
      n++;
      start = (n == glitch);
      if (start) begin
        fill = ~f; src_addr = AW'($urandom); dst_addr = AW'($urandom); len = 1;
      end
      if (req) nacc++;
      if (req && we) begin
        wr_addr.push_back(addr);
        wr_cyc.push_back(n);
      end
      if (done) begin
        err_seen = error;
        if (busy) bad_busy++;
        break;
      end
      if (!busy) bad_busy++;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, n, exp_done);
    chk({tag, " error"}, {31'b0, err_seen}, {31'b0, rejected});
    chk({tag, " busy_window"}, bad_busy, 0);
    chk({tag, " accesses"}, nacc, exp_acc);
    @(negedge clk);
    chk({tag, " done_pulse"}, {29'b0, done, error, busy}, 0);
    mm = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== ref_mem[i]) mm++;
    chk({tag, " mem_words_wrong"}, mm, 0);
  endtask

  initial begin
    int nd;
    logic [AW-1:0] rs, rd;
    for (int i = 0; i < NW; i++) poke(i, $urandom);
    chk("reset outputs", {25'b0, busy, done, error, req, we, be}, 0);
    chk("reset addr", {20'b0, addr}, 0);
    chk("reset wdata", wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test-plan copy: four words 0x000 -> 0x100.
    poke(0, 32'h11111111); poke(1, 32'h22222222); poke(2, 32'h33333333); poke(3, 32'h44444444);
    run(1'b0, 12'h000, 12'h100, 4, 32'h0, 0, "copy4");
    chk("copy4 dst0", mem[12'h100 >> 2], 32'h11111111);
    chk("copy4 dst3", mem[(12'h100 >> 2) + 3], 32'h44444444);

    // Test-plan fill: three words at 0x40, neighbour at 0x4C untouched.
    poke(12'h4C >> 2, 32'h12345678);
    run(1'b1, 12'h000, 12'h040, 3, 32'hDEADBEEF, 0, "fill3");
    chk("fill3 nwrites", wr_addr.size(), 3);
    chk("fill3 wr0", {20'b0, wr_addr[0]}, 12'h040);
    chk("fill3 wr1", {20'b0, wr_addr[1]}, 12'h044);
    chk("fill3 wr2", {20'b0, wr_addr[2]}, 12'h048);
    chk("fill3 consecutive", wr_cyc[2] - wr_cyc[0], 2);
    chk("fill3 0x4C", mem[12'h4C >> 2], 32'h12345678);

    run(1'b0, 12'h000, 12'h200, 0, 32'h0, 0, "len0");
    run(1'b0, 12'h002, 12'h200, 3, 32'h0, 0, "copy_misaligned_src");
    run(1'b1, 12'h002, 12'h000, 2, 32'hCAFEF00D, 0, "fill_misaligned_src");
    run(1'b1, 12'h000, 12'h081, 2, 32'hCAFEF00D, 0, "fill_misaligned_dst");

    // Overlapping copy propagates word A forward; a mid-transfer start is ignored.
    poke(0, 32'hAAAA0001); poke(1, 32'hBBBB0002); poke(2, 32'hCCCC0003); poke(3, 32'hDDDD0004);
    run(1'b0, 12'h000, 12'h004, 3, 32'h0, 3, "overlap");
    chk("overlap w1", mem[1], 32'hAAAA0001);
    chk("overlap w3", mem[3], 32'hAAAA0001);

    run(1'b1, 12'h000, 12'hFFC, 2, 32'h5A5A5A5A, 0, "wrap");
    chk("wrap nwrites", wr_addr.size(), 2);
    chk("wrap wr0", {20'b0, wr_addr[0]}, 12'hFFC);
    chk("wrap wr1", {20'b0, wr_addr[1]}, 12'h000);

    // Asynchronous reset during the first WRITE of a copy.
    @(negedge clk);
    fill = 1'b0; src_addr = 12'h200; dst_addr = 12'h300; len = 4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    while (!we && nd < 10) begin
      @(negedge clk);
      nd++;
    end
    chk("rst reached write", {31'b0, we}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async outputs", {25'b0, busy, done, error, req, we, be}, 0);
    chk("rst async addr", {20'b0, addr}, 0);
    chk("rst async wdata", wdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rst no done", nd, 0);
    run(1'b0, 12'h200, 12'h300, 4, 32'h0, 0, "after_reset");

    for (int it = 0; it < 10; it++) begin
      rs = AW'($urandom) & 12'hFFC;
      rd = AW'($urandom) & 12'hFFC;
      if ($urandom_range(0, 5) == 0) rs = rs | 12'h002;
      if ($urandom_range(0, 7) == 0) rd = rd | 12'h001;
      run(1'($urandom_range(0, 1)), rs, rd, LW'($urandom_range(1, 8)), $urandom, 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
